// File: rtl/dmem_responder.sv
// Handshaked multi-cycle word memory for the datapath dmem port.
// Optional: define DMEM_RESP_MISALIGN_CHECK_EN to flag misaligned accesses.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_wmask,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_n;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] h_idx;
    logic [1:0]    h_off;
    logic          h_we;
    logic [3:0]    h_wmask;
    logic [31:0]   h_wdata;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          access;
    logic          err;
    logic          unused;

    assign unused = ^{req_addr[31:AW+2], h_off};
    assign accept = (state == IDLE) && req_valid;
    assign access = (state == WAIT) && (cnt == '0);

`ifdef DMEM_RESP_MISALIGN_CHECK_EN
    logic st_ok;
    always_comb begin
        st_ok = (h_wmask == (4'b0001 << h_off))
             || (!h_off[0] && (h_wmask == (4'b0011 << h_off)))
             || ((h_off == 2'b00) && (h_wmask == 4'b1111));
        err = h_we ? !st_ok : (h_off != 2'b00);
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n    = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid)
                    state_n = WAIT;
            end
            WAIT: begin
                if (cnt == '0)
                    state_n = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_idx      <= '0;
            h_off      <= '0;
            h_we       <= 1'b0;
            h_wmask    <= '0;
            h_wdata    <= '0;
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                h_idx   <= req_addr[AW+1:2];
                h_off   <= req_addr[1:0];
                h_we    <= req_we;
                h_wmask <= req_wmask;
                h_wdata <= req_wdata;
                cnt     <= CW'(LATENCY - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (access) begin
                resp_err   <= err;
                resp_rdata <= (h_we || err) ? 32'h0 : mem[h_idx];
            end
        end
    end

    // Array is not reset; a reset mid-WAIT leaves state IDLE so nothing commits.
    always_ff @(posedge clk) begin
        if (access && h_we && !err) begin
            for (int b = 0; b < 4; b++)
                if (h_wmask[b])
                    mem[h_idx][8*b +: 8] <= h_wdata[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [3:0]  req_wmask;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .req_we(req_we),
        .req_wmask(req_wmask),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Drive one request, return edges from accept to resp_valid (99 = timeout).
    task automatic txn_start(input logic [31:0] a, input logic we,
                             input logic [3:0] m, input logic [31:0] d,
                             output int lat);
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = we;
        req_wmask = m;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_we    = ~we;
        req_wmask = 4'hF;
        req_wdata = 32'h5A5A_5A5A;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_txn(input logic [31:0] a, input logic we,
                          input logic [3:0] m, input logic [31:0] d,
                          output logic [31:0] rd, output logic er,
                          output int lat);
        resp_ready = 1'b1;
        txn_start(a, we, m, d, lat);
        rd = resp_rdata;
        er = resp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_we     = 1'b0;
        req_wmask  = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_req_ready got %b want 1", req_ready);
        end
        n_checks++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resp_valid got %b want 0", resp_valid);
        end
        n_checks++;
        if (resp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata got %h want 0", resp_rdata);
        end
        n_checks++;
        if (resp_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err_busy got %b%b want 00", resp_err, busy);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load;
        logic [31:0] rd;
        logic er;
        int lat;
        do_txn(32'h10, 1'b1, 4'b1111, 32'hDEADBEEF, rd, er, lat);
        n_checks++;
        if (lat != 2 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL store_lat_rdata got lat=%0d rd=%h want lat=2 rd=0", lat, rd);
        end
        do_txn(32'h10, 1'b0, 4'b0000, 32'h0, rd, er, lat);
        n_checks++;
        if (lat != 2) begin
            n_fail++;
            $display("FAIL load_latency got %0d want 2", lat);
        end
        n_checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL load_data got %h err=%b want deadbeef err=0", rd, er);
        end
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_idle got rdy=%b vld=%b busy=%b want 1 0 0",
                     req_ready, resp_valid, busy);
        end
    endtask

    task automatic test_wmask;
        logic [31:0] rd;
        logic er;
        int lat;
        do_txn(32'h20, 1'b1, 4'b1111, 32'h11223344, rd, er, lat);
        do_txn(32'h20, 1'b1, 4'b0101, 32'hAABBCCDD, rd, er, lat);
        do_txn(32'h20, 1'b0, 4'b0000, 32'h0, rd, er, lat);
        n_checks++;
        if (rd !== 32'h11BB33DD) begin
            n_fail++;
            $display("FAIL wmask_merge got %h want 11bb33dd", rd);
        end
        do_txn(32'h20, 1'b1, 4'b0000, 32'hFFFFFFFF, rd, er, lat);
        do_txn(32'h20, 1'b0, 4'b0000, 32'h0, rd, er, lat);
        n_checks++;
        if (rd !== 32'h11BB33DD) begin
            n_fail++;
            $display("FAIL wmask_zero got %h want 11bb33dd", rd);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        resp_ready = 1'b0;
        txn_start(32'h10, 1'b0, 4'b0000, 32'h0, lat);
        n_checks++;
        if (lat != 2) begin
            n_fail++;
            $display("FAIL bp_latency got %0d want 2", lat);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 ||
                resp_rdata !== 32'hDEADBEEF) begin
                n_fail++;
                $display("FAIL bp_stall%0d got vld=%b rdy=%b rd=%h want 1 0 deadbeef",
                         i, resp_valid, req_ready, resp_rdata);
            end
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release got vld=%b rdy=%b want 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_alias;
        logic [31:0] rd;
        logic er;
        int lat;
        do_txn(32'h000, 1'b1, 4'b1111, 32'h12345678, rd, er, lat);
        do_txn(32'h400, 1'b0, 4'b0000, 32'h0, rd, er, lat);
        n_checks++;
        if (rd !== 32'h12345678) begin
            n_fail++;
            $display("FAIL alias_wrap got %h want 12345678", rd);
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] rd;
        logic er;
        int lat;
        do_txn(32'h30, 1'b1, 4'b1111, 32'hCAFEF00D, rd, er, lat);
        req_valid = 1'b1;
        req_addr  = 32'h30;
        req_we    = 1'b1;
        req_wmask = 4'b1111;
        req_wdata = 32'h0BADBEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_immediate got rdy=%b vld=%b busy=%b want 1 0 0",
                     req_ready, resp_valid, busy);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_resp got %b want 0", resp_valid);
        end
        do_txn(32'h30, 1'b0, 4'b0000, 32'h0, rd, er, lat);
        n_checks++;
        if (rd !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL abort_not_committed got %h want cafef00d", rd);
        end
    endtask

    task automatic test_misalign;
        logic [31:0] rd;
        logic er;
        int lat;
        do_txn(32'h40, 1'b1, 4'b1111, 32'h55667788, rd, er, lat);
        do_txn(32'h42, 1'b0, 4'b0000, 32'h0, rd, er, lat);
`ifdef DMEM_RESP_MISALIGN_CHECK_EN
        n_checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL misalign_load got err=%b rd=%h want 1 0", er, rd);
        end
        do_txn(32'h41, 1'b1, 4'b1111, 32'hFFFFFFFF, rd, er, lat);
        n_checks++;
        if (er !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_store_err got %b want 1", er);
        end
        do_txn(32'h40, 1'b0, 4'b0000, 32'h0, rd, er, lat);
        n_checks++;
        if (rd !== 32'h55667788 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_store_mem got %h err=%b want 55667788 0", rd, er);
        end
`else
        n_checks++;
        if (er !== 1'b0 || rd !== 32'h55667788) begin
            n_fail++;
            $display("FAIL unaligned_load got err=%b rd=%h want 0 55667788", er, rd);
        end
        do_txn(32'h41, 1'b1, 4'b0010, 32'h0000AA00, rd, er, lat);
        do_txn(32'h40, 1'b0, 4'b0000, 32'h0, rd, er, lat);
        n_checks++;
        if (rd !== 32'h5566AA88 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_store got %h err=%b want 5566aa88 0", rd, er);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_wmask;
        test_backpressure;
        test_alias;
        test_reset_abort;
        test_misalign;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
